huffman_stream_decoder: RTL

- Receive end of the Huffman output path: accepts packed encoded text as 32-bit words, MSB-first, in the same order the packer produces them (word 0 = first bits), and recovers the symbol stream.
- Code table (symbol, code, length) is loaded through a write port before decoding.
- Bits are consumed one per cycle and matched against the table. Each decoded symbol is emitted on a valid/ready handshake.
- Stops after exactly total_bit_i bits; flags undecodable input.

---
 rtl/huffman_stream_decoder_if.sv | 41 ++++
 rtl/huffman_stream_decoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/huffman_stream_decoder_if.sv
// Handshake and table-load bundle for the Huffman stream decoder.
// The master side feeds words and table entries; the slave side is the decoder.
interface huffman_stream_decoder_if #(
    parameter int BIT_WIDTH  = 8,
    parameter int TEXT_WIDTH = 32,
    parameter int MAX_TEXT   = 1024,
    parameter int MAX_LEN    = 16,
    parameter int NUM_CODES  = 32
);
    localparam int AW = $clog2(NUM_CODES);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(MAX_TEXT + 1);

    logic                  tbl_we_i;
    logic [AW-1:0]         tbl_addr_i;
    logic [BIT_WIDTH-1:0]  tbl_sym_i;
    logic [MAX_LEN-1:0]    tbl_code_i;
    logic [LW-1:0]         tbl_len_i;
    logic                  start_i;
    logic [CW-1:0]         total_bit_i;
    logic                  word_valid_i;
    logic [TEXT_WIDTH-1:0] word_i;
    logic                  word_ready_o;
    logic                  sym_valid_o;
    logic [BIT_WIDTH-1:0]  sym_o;
    logic                  sym_ready_i;
    logic                  done_o;
    logic                  error_o;

    modport master (
        output tbl_we_i, tbl_addr_i, tbl_sym_i, tbl_code_i, tbl_len_i,
        output start_i, total_bit_i, word_valid_i, word_i, sym_ready_i,
        input  word_ready_o, sym_valid_o, sym_o, done_o, error_o
    );

    modport slave (
        input  tbl_we_i, tbl_addr_i, tbl_sym_i, tbl_code_i, tbl_len_i,
        input  start_i, total_bit_i, word_valid_i, word_i, sym_ready_i,
        output word_ready_o, sym_valid_o, sym_o, done_o, error_o
    );
endinterface

// File: rtl/huffman_stream_decoder.sv
// Bit-serial Huffman decoder: unpacks MSB-first words and matches a growing
// code accumulator against a loadable table, one bit per cycle.
module huffman_stream_decoder #(
    parameter int BIT_WIDTH  = 8,
    parameter int TEXT_WIDTH = 32,
    parameter int MAX_TEXT   = 1024,
    parameter int MAX_LEN    = 16,
    parameter int NUM_CODES  = 32
) (
    input logic clk_i,
    input logic rst_i,
    huffman_stream_decoder_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(MAX_TEXT + 1);
    localparam int IW = $clog2(TEXT_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, EMIT, DONE, ERR} state_t;

    state_t state;

    logic [BIT_WIDTH-1:0]  t_sym  [NUM_CODES];
    logic [MAX_LEN-1:0]    t_code [NUM_CODES];
    logic [LW-1:0]         t_len  [NUM_CODES];

    logic [CW-1:0]         total;
    logic [CW-1:0]         consumed;
    logic [MAX_LEN-1:0]    acc;
    logic [LW-1:0]         acc_len;
    logic [TEXT_WIDTH-1:0] shift_reg;
    logic [IW-1:0]         bit_idx;

    logic                  idle_like;
    logic [MAX_LEN-1:0]    acc_next;
    logic [MAX_LEN-1:0]    len_mask;
    logic [LW-1:0]         len_next;
    logic [CW-1:0]         consumed_next;
    logic [CW-1:0]         total_sat;
    logic                  hit;
    logic [BIT_WIDTH-1:0]  hit_sym;

    assign idle_like     = (state == IDLE) || (state == DONE) || (state == ERR);
    assign acc_next      = {acc[MAX_LEN-2:0], shift_reg[TEXT_WIDTH-1]};
    assign len_next      = acc_len + LW'(1);
    assign consumed_next = consumed + CW'(1);
    assign len_mask      = {MAX_LEN{1'b1}} >> (LW'(MAX_LEN) - len_next);
    assign total_sat     = (bus.total_bit_i > CW'(MAX_TEXT)) ? CW'(MAX_TEXT)
                                                             : bus.total_bit_i;

    // Table storage; only writable while no message is in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CODES; i++) begin
                t_sym[i]  <= '0;
                t_code[i] <= '0;
                t_len[i]  <= '0;
            end
        end else if (bus.tbl_we_i && idle_like) begin
            t_sym[bus.tbl_addr_i]  <= bus.tbl_sym_i;
            t_code[bus.tbl_addr_i] <= bus.tbl_code_i;
            t_len[bus.tbl_addr_i]  <= bus.tbl_len_i;
        end
    end

    // Search the table for the next accumulator value; lowest index wins.
    always_comb begin
        hit     = 1'b0;
        hit_sym = '0;
        for (int i = NUM_CODES - 1; i >= 0; i--) begin
            if (t_len[i] == len_next && (t_code[i] & len_mask) == acc_next) begin
                hit     = 1'b1;
                hit_sym = t_sym[i];
            end
        end
    end

    // Decoder FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            total            <= '0;
            consumed         <= '0;
            acc              <= '0;
            acc_len          <= '0;
            shift_reg        <= '0;
            bit_idx          <= '0;
            bus.word_ready_o <= 1'b0;
            bus.sym_valid_o  <= 1'b0;
            bus.sym_o        <= '0;
            bus.done_o       <= 1'b0;
            bus.error_o      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start_i) begin
                        total       <= total_sat;
                        consumed    <= '0;
                        acc         <= '0;
                        acc_len     <= '0;
                        bus.error_o <= 1'b0;
                        if (total_sat == '0) begin
                            state      <= DONE;
                            bus.done_o <= 1'b1;
                        end else begin
                            state            <= LOAD;
                            bus.done_o       <= 1'b0;
                            bus.word_ready_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.word_valid_i) begin
                        shift_reg        <= bus.word_i;
                        bit_idx          <= '0;
                        bus.word_ready_o <= 1'b0;
                        state            <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    bit_idx   <= bit_idx + IW'(1);
                    consumed  <= consumed_next;
                    if (hit) begin
                        bus.sym_o       <= hit_sym;
                        bus.sym_valid_o <= 1'b1;
                        acc             <= '0;
                        acc_len         <= '0;
                        state           <= EMIT;
                    end else begin
                        acc     <= acc_next;
                        acc_len <= len_next;
                        if (len_next == LW'(MAX_LEN) || consumed_next == total) begin
                            bus.error_o <= 1'b1;
                            state       <= ERR;
                        end else if (bit_idx == IW'(TEXT_WIDTH - 1)) begin
                            bus.word_ready_o <= 1'b1;
                            state            <= LOAD;
                        end
                    end
                end
                EMIT: begin
                    if (bus.sym_ready_i) begin
                        bus.sym_valid_o <= 1'b0;
                        if (consumed == total) begin
                            bus.done_o <= 1'b1;
                            state      <= DONE;
                        end else if (bit_idx == IW'(TEXT_WIDTH)) begin
                            bus.word_ready_o <= 1'b1;
                            state            <= LOAD;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
